// File: rtl/karat_pkg.sv
// Shared constants and FSM state type for the restoring divider.
package karat_pkg;

    localparam int KARAT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/karat_div_step.sv
// One restoring-division step: shift in a dividend bit, compare against Y, subtract on success.
module karat_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem,
    input  logic             din,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   rem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] y_ext;

    // The incoming remainder is always < Y, so its top bit is zero and the shift cannot overflow.
    assign shifted  = {rem[WIDTH-1:0], din};
    assign y_ext    = {1'b0, y};
    assign qbit     = (shifted >= y_ext);
    assign rem_next = qbit ? (shifted - y_ext) : shifted;

endmodule

// File: rtl/karat_div.sv
// Iterative 2W/W restoring divider with valid/ready handshakes and divide-by-zero / overflow flags.
module karat_div
    import karat_pkg::*;
#(
    parameter int WIDTH = KARAT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   XY,
    input  logic [WIDTH-1:0]     Y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     X,
    output logic [WIDTH-1:0]     R,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state_reg;
    logic [WIDTH:0]    rem_reg;
    logic [WIDTH-1:0]  dvd_reg;
    logic [WIDTH-1:0]  y_reg;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  x_reg;
    logic [WIDTH-1:0]  r_reg;
    logic              dbz_reg;
    logic              ovf_reg;

    logic [WIDTH:0]    step_rem;
    logic              step_q;
    logic              accept;
    logic              last_step;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    assign X   = x_reg;
    assign R   = r_reg;
    assign dbz = dbz_reg;
    assign ovf = ovf_reg;

    karat_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .din      (dvd_reg[WIDTH-1]),
        .y        (y_reg),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
            x_reg     <= '0;
            r_reg     <= '0;
            dbz_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        y_reg   <= Y;
                        cnt_reg <= '0;
                        dbz_reg <= 1'b0;
                        ovf_reg <= 1'b0;
                        if (Y == '0) begin
                            x_reg     <= '1;
                            r_reg     <= XY[WIDTH-1:0];
                            dbz_reg   <= 1'b1;
                            state_reg <= DONE;
                        end else if (XY[2*WIDTH-1:WIDTH] >= Y) begin
                            // Quotient would not fit in WIDTH bits.
                            x_reg     <= '1;
                            r_reg     <= '0;
                            ovf_reg   <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            rem_reg   <= {1'b0, XY[2*WIDTH-1:WIDTH]};
                            dvd_reg   <= XY[WIDTH-1:0];
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    rem_reg <= step_rem;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], step_q};
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_step) begin
                        x_reg     <= {dvd_reg[WIDTH-2:0], step_q};
                        r_reg     <= step_rem[WIDTH-1:0];
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_karat_div.sv
// Self-checking bench for karat_div: directed corner cases plus randomized operations against an arithmetic model.
module tb_karat_div;

    localparam int W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   XY;
    logic [W-1:0]     Y;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     X;
    logic [W-1:0]     R;
    logic             dbz;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    karat_div #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .XY        (XY),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X),
        .R         (R),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the quotient/remainder the spec defines, computed with plain arithmetic.
    task automatic model(input longint xy, input longint y,
                         output longint ex, output longint er,
                         output longint ed, output longint eo, output longint lat);
        if (y == 0) begin
            ex = 65535; er = xy % 65536; ed = 1; eo = 0; lat = 1;
        end else if ((xy / 65536) >= y) begin
            ex = 65535; er = 0; ed = 0; eo = 1; lat = 1;
        end else begin
            ex = xy / y; er = xy % y; ed = 0; eo = 0; lat = W + 1;
        end
    endtask

    task automatic run_op(input logic [2*W-1:0] xy, input logic [W-1:0] y, input int hold);
        longint ex, er, ed, eo, lat;
        int n;
        logic [W-1:0] sx, sr;
        logic sd, so;
        model(xy, y, ex, er, ed, eo, lat);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("wait_in_ready", longint'(in_ready), 1);
        in_valid = 1'b1; XY = xy; Y = y;
        @(posedge clk);
        @(negedge clk);
        // Keep in_valid high with garbage operands: must be ignored while busy.
        XY = $urandom; Y = W'($urandom);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("latency", n, lat);
        chk("X", longint'(X), ex);
        chk("R", longint'(R), er);
        chk("dbz", longint'(dbz), ed);
        chk("ovf", longint'(ovf), eo);
        if (dbz == 1'b0 && ovf == 1'b0)
            chk("identity", longint'(X) * longint'(y) + longint'(R), longint'(xy));
        $display("op XY=%0d Y=%0d -> X=%0d R=%0d dbz=%0d ovf=%0d lat=%0d",
                 xy, y, X, R, dbz, ovf, n);
        sx = X; sr = R; sd = dbz; so = ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_stable", longint'({X, R, dbz, ovf}), longint'({sx, sr, sd, so}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_handoff_valid", longint'(out_valid), 0);
        chk("post_handoff_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        logic [2*W-1:0] rxy;
        logic [W-1:0]   ry;
        int mode;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; XY = '0; Y = '0;
        #12;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_outputs", longint'({X, R, dbz, ovf}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd15, 16'd5, 0);
        run_op(32'd7006652, 16'd5678, 0);
        run_op(32'd7006669, 16'd5678, 1);
        run_op(32'd65025, 16'd0, 0);
        run_op(32'h0005_0000, 16'd5, 0);
        run_op(32'h0004_FFFF, 16'd5, 5);

        // Abort mid-iteration with reset.
        in_valid = 1'b1; XY = 32'd255; Y = 16'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); @(negedge clk);
            chk("abort_no_stale", longint'({out_valid, in_ready}), 1);
        end
        $display("reset abort during 255/7 observed idle after release");
        run_op(32'd255, 16'd7, 0);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 9));
            ry = W'($urandom);
            if (mode == 0) ry = '0;
            else if (ry == '0) ry = 16'd1;
            if (mode == 1)
                rxy = {ry + W'($urandom_range(0, 3) * (ry != 16'hFFFF)), W'($urandom)};
            else if (mode == 2)
                rxy = {W'($urandom), W'($urandom)};
            else
                rxy = {W'($urandom % ((ry == '0) ? 32'd65536 : 32'(ry))), W'($urandom)};
            run_op(rxy, ry, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
